// File: rtl/tile_pkg.sv
// Shared constants, state encoding and helpers for the tile map sequencer.
// Map geometry and the "empty" tile code live here so cursor and FSM agree.
package tile_pkg;
  localparam int MAP_COLS = 20;
  localparam int MAP_ROWS = 15;
  localparam int TILE_PX  = 8;
  localparam int GUARD    = 2;
  localparam logic [7:0] SKIP_ID = 8'hFF;

  localparam int COL_W   = $clog2(MAP_COLS);
  localparam int ROW_W   = $clog2(MAP_ROWS);
  localparam int ADDR_W  = $clog2(MAP_COLS * MAP_ROWS);
  localparam int GUARD_W = $clog2(GUARD + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT_MAP,
    S_ISSUE,
    S_GUARD_WAIT,
    S_WAIT_DRW,
    S_ADVANCE,
    S_DONE
  } state_t;

  // Pixel origin of a tile index, truncated to the 8-bit screen coordinate.
  function automatic logic [7:0] px_origin(input logic [7:0] idx);
    logic [15:0] p;
    p = 16'(idx) * 16'(TILE_PX);
    return p[7:0];
  endfunction
endpackage

// File: rtl/tile_cursor.sv
// Column/row walker over the tile map with a running row base, so the map
// address row*MAP_COLS+col needs only an adder.
module tile_cursor
  import tile_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clear,
  input  logic              i_advance,
  output logic [COL_W-1:0]  o_col,
  output logic [ROW_W-1:0]  o_row,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(MAP_COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(MAP_ROWS - 1);

  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [ADDR_W-1:0] r_row_base;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_col      <= '0;
      r_row      <= '0;
      r_row_base <= '0;
    end else if (i_advance) begin
      if (r_col == COL_LAST) begin
        r_col      <= '0;
        r_row      <= r_row + ROW_W'(1);
        r_row_base <= r_row_base + ADDR_W'(MAP_COLS);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  assign o_col  = r_col;
  assign o_row  = r_row;
  assign o_addr = r_row_base + ADDR_W'(r_col);
  assign o_last = (r_col == COL_LAST) && (r_row == ROW_LAST);
endmodule

// File: rtl/tilemap_sequencer.sv
// Walks the tile map row-major on start and hands each non-empty tile to the
// drawer, waiting for the drawer to go idle before moving on.
module tilemap_sequencer
  import tile_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  output logic [ADDR_W-1:0] o_map_rd_addr,
  input  logic [7:0]        i_map_rd_data,
  input  logic              i_drawer_idle,
  output logic [7:0]        o_tile_address,
  output logic [7:0]        o_x_pos,
  output logic [7:0]        o_y_pos,
  output logic              o_draw,
  output logic              o_busy,
  output logic              o_frame_done
);
  state_t             r_state;
  logic               r_rd_phase;
  logic [7:0]         r_map_data;
  logic [GUARD_W-1:0] r_guard;

  logic [COL_W-1:0]   w_col;
  logic [ROW_W-1:0]   w_row;
  logic [ADDR_W-1:0]  w_addr;
  logic               w_last;
  logic               w_clear;
  logic               w_advance;

  assign w_clear   = (r_state == S_IDLE) && i_start;
  assign w_advance = (r_state == S_ADVANCE);

  tile_cursor u_cursor (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (w_clear),
    .i_advance (w_advance),
    .o_col     (w_col),
    .o_row     (w_row),
    .o_addr    (w_addr),
    .o_last    (w_last)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_rd_phase     <= 1'b0;
      r_map_data     <= '0;
      r_guard        <= '0;
      o_map_rd_addr  <= '0;
      o_tile_address <= '0;
      o_x_pos        <= '0;
      o_y_pos        <= '0;
      o_draw         <= 1'b0;
      o_busy         <= 1'b0;
      o_frame_done   <= 1'b0;
    end else begin
      o_draw       <= 1'b0;
      o_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            o_busy  <= 1'b1;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          o_map_rd_addr <= w_addr;
          r_rd_phase    <= 1'b0;
          r_state       <= S_WAIT_MAP;
        end
        // First cycle lets the RAM register the address; data is valid on the second.
        S_WAIT_MAP: begin
          r_rd_phase <= 1'b1;
          if (r_rd_phase) begin
            r_map_data <= i_map_rd_data;
            r_state    <= (i_map_rd_data == SKIP_ID) ? S_ADVANCE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          o_tile_address <= r_map_data;
          o_x_pos        <= px_origin(8'(w_col));
          o_y_pos        <= px_origin(8'(w_row));
          o_draw         <= 1'b1;
          r_guard        <= GUARD_W'(GUARD);
          r_state        <= (GUARD == 0) ? S_WAIT_DRW : S_GUARD_WAIT;
        end
        // The drawer may still report idle for a cycle or two after draw.
        S_GUARD_WAIT: begin
          r_guard <= r_guard - GUARD_W'(1);
          if (r_guard == GUARD_W'(1)) r_state <= S_WAIT_DRW;
        end
        S_WAIT_DRW: begin
          if (i_drawer_idle) r_state <= S_ADVANCE;
        end
        S_ADVANCE: begin
          if (w_last) begin
            o_frame_done <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_state <= S_READ;
          end
        end
        S_DONE: begin
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tilemap_sequencer.sv
// Randomized bench for tilemap_sequencer: sync map RAM, configurable drawer
// model, and an expected draw list derived directly from the map contents.
module tb_tilemap_sequencer;
  localparam int NT = 300;

  logic       clk = 1'b0;
  logic       reset, start, drawer_idle;
  logic [8:0] map_rd_addr;
  logic [7:0] map_rd_data, tile_address, x_pos, y_pos;
  logic       draw, busy, frame_done;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [NT];

  // drawer model config and state
  int d_pre = 0, d_busy = 1;
  int pre_cnt, busy_cnt;
  bit active;

  // observed draws
  logic [7:0] got_ta[$], got_x[$], got_y[$];
  logic [8:0] got_ma[$];
  int viol = 0;
  int fd_cnt = 0;

  tilemap_sequencer dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_start        (start),
    .o_map_rd_addr  (map_rd_addr),
    .i_map_rd_data  (map_rd_data),
    .i_drawer_idle  (drawer_idle),
    .o_tile_address (tile_address),
    .o_x_pos        (x_pos),
    .o_y_pos        (y_pos),
    .o_draw         (draw),
    .o_busy         (busy),
    .o_frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    map_rd_data <= (map_rd_addr < 9'(NT)) ? mem[map_rd_addr] : 8'hFF;

  always @(posedge clk) begin
    if (reset) begin
      drawer_idle <= 1'b1;
      active      <= 1'b0;
    end else if (draw) begin
      pre_cnt  <= d_pre;
      busy_cnt <= d_busy;
      active   <= 1'b1;
      if (d_pre == 0) drawer_idle <= 1'b0;
    end else if (active) begin
      if (pre_cnt > 0) begin
        pre_cnt <= pre_cnt - 1;
        if (pre_cnt == 1) drawer_idle <= 1'b0;
      end else if (busy_cnt > 1) begin
        busy_cnt <= busy_cnt - 1;
      end else begin
        drawer_idle <= 1'b1;
        active      <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (draw) begin
      got_ta.push_back(tile_address);
      got_x.push_back(x_pos);
      got_y.push_back(y_pos);
      got_ma.push_back(map_rd_addr);
      if (active || !drawer_idle) viol++;
    end
    if (frame_done) fd_cnt++;
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_got();
    got_ta.delete(); got_x.delete(); got_y.delete(); got_ma.delete();
    viol = 0;
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < NT; i++) mem[i] = v;
  endtask

  // Pulses start, optionally re-pulses it at cycles inj0/inj1, and returns
  // the cycle offset of frame_done (-1 on timeout).
  task automatic run_frame(input int budget, input int inj0, input int inj1,
                           output int lat, output int busy_low);
    int c;
    bit seen;
    busy_low = 0;
    @(posedge clk); #1 start = 1'b1;
    c = 0; seen = 0;
    while (!seen && c < budget) begin
      @(negedge clk);
      if (c > 0 && frame_done) seen = 1;
      else if (c > 0 && !busy) busy_low++;
      @(posedge clk); #1;
      c++;
      start = (c == inj0 || c == inj1);
    end
    start = 1'b0;
    lat = seen ? c - 1 : -1;
  endtask

  task automatic cmp_draws(input string tag);
    logic [7:0] e_ta[$], e_x[$], e_y[$];
    logic [8:0] e_ma[$];
    int n;
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 20; c++)
        if (mem[r*20 + c] != 8'hFF) begin
          e_ta.push_back(mem[r*20 + c]);
          e_x.push_back(8'(c * 8));
          e_y.push_back(8'(r * 8));
          e_ma.push_back(9'(r*20 + c));
        end
    chk({tag, "_ndraw"}, got_ta.size(), e_ta.size());
    chk({tag, "_busydraw"}, viol, 0);
    n = (got_ta.size() < e_ta.size()) ? got_ta.size() : e_ta.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_ta%0d", tag, i), got_ta[i], e_ta[i]);
      chk($sformatf("%s_x%0d",  tag, i), got_x[i],  e_x[i]);
      chk($sformatf("%s_y%0d",  tag, i), got_y[i],  e_y[i]);
      chk($sformatf("%s_ma%0d", tag, i), got_ma[i], e_ma[i]);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_draw"}, draw, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_fd"}, frame_done, 0);
    chk({tag, "_mra"}, map_rd_addr, 0);
    chk({tag, "_ta"}, tile_address, 0);
    chk({tag, "_x"}, x_pos, 0);
    chk({tag, "_y"}, y_pos, 0);
  endtask

  initial begin
    int lat, bl, fd0, k;
    reset = 1'b1; start = 1'b0;
    fill(8'hFF);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_zero("rst");

    // all-empty map: fixed latency, no draws
    clear_got(); fd0 = fd_cnt;
    run_frame(5000, -1, -1, lat, bl);
    chk("skip_lat", lat, 4*NT + 1);
    chk("skip_busy", bl, 0);
    chk("skip_fd", fd_cnt - fd0, 1);
    cmp_draws("skip");

    // single tile at (0,0), long drawer
    fill(8'hFF); mem[0] = 8'h10; d_pre = 0; d_busy = 600;
    clear_got(); fd0 = fd_cnt;
    run_frame(5000, -1, -1, lat, bl);
    chk("t00_to", lat >= 0, 1);
    chk("t00_fd", fd_cnt - fd0, 1);
    cmp_draws("t00");

    // last tile (19,14)
    fill(8'hFF); mem[299] = 8'h22; d_busy = 3;
    clear_got();
    run_frame(5000, -1, -1, lat, bl);
    chk("tlast_to", lat >= 0, 1);
    cmp_draws("tlast");

    // slow drawer: idle stays high one cycle after draw, adjacent tiles
    fill(8'hFF); mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[20] = 8'h04;
    d_pre = 1; d_busy = 5;
    clear_got();
    run_frame(5000, -1, -1, lat, bl);
    chk("slow_to", lat >= 0, 1);
    cmp_draws("slow");

    // start while busy and in the frame_done cycle: ignored
    fill(8'hFF); clear_got(); fd0 = fd_cnt;
    run_frame(5000, 600, 4*NT + 1, lat, bl);
    chk("rst_busy_lat", lat, 4*NT + 1);
    repeat (1400) @(posedge clk);
    #1;
    chk("ign_fd", fd_cnt - fd0, 1);
    chk("ign_busy", busy, 0);

    // reset while waiting on the drawer
    fill(8'hFF); mem[0] = 8'h33; mem[5] = 8'h44; d_pre = 0; d_busy = 100;
    clear_got();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = 0;
    while (got_ta.size() == 0 && k < 200) begin @(posedge clk); #1; k++; end
    chk("rmid_to", got_ta.size(), 1);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk_zero("rmid");
    repeat (300) @(posedge clk);
    #1;
    chk("rmid_nodraw", got_ta.size(), 1);
    clear_got(); d_busy = 4;
    run_frame(5000, -1, -1, lat, bl);
    chk("rmid2_to", lat >= 0, 1);
    cmp_draws("rmid2");

    // random maps and drawer timing
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < NT; i++)
        mem[i] = ($urandom_range(0, 99) < 30) ? 8'($urandom_range(0, 254)) : 8'hFF;
      d_pre = $urandom_range(0, 3); d_busy = $urandom_range(1, 10);
      clear_got(); fd0 = fd_cnt;
      run_frame(20000, -1, -1, lat, bl);
      chk($sformatf("rnd%0d_to", t), lat >= 0, 1);
      chk($sformatf("rnd%0d_busy", t), bl, 0);
      chk($sformatf("rnd%0d_fd", t), fd_cnt - fd0, 1);
      cmp_draws($sformatf("rnd%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
